silife_max7219_sink: RTL

Behavioural-synthesisable MAX7219 daisy-chain receiver: the device-side counterpart of the silife MAX7219 SPI driver. It samples CS/SCK/MOSI in the system clock domain and shifts frames through a chain of DEVICES emulated MAX7219s. On each CS rising edge it decodes every device's 16-bit command into a per-device register file (8 digit rows plus control registers). Used as an on-chip loopback and self-check target for the display path, and as a bench scoreboard source.

---
 rtl/silife_max7219_pkg.sv | 32 +++
 rtl/silife_max7219_sink_reg.sv | 46 ++++
 rtl/silife_max7219_sink.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/silife_max7219_pkg.sv
// Shared MAX7219 register map and per-device control bundle
// used by both the SPI driver and the chain receiver.
package silife_max7219_pkg;

  localparam logic [3:0] NOOP         = 4'h0;
  localparam logic [3:0] DIGIT0       = 4'h1;
  localparam logic [3:0] DIGIT1       = 4'h2;
  localparam logic [3:0] DIGIT2       = 4'h3;
  localparam logic [3:0] DIGIT3       = 4'h4;
  localparam logic [3:0] DIGIT4       = 4'h5;
  localparam logic [3:0] DIGIT5       = 4'h6;
  localparam logic [3:0] DIGIT6       = 4'h7;
  localparam logic [3:0] DIGIT7       = 4'h8;
  localparam logic [3:0] DECODE       = 4'h9;
  localparam logic [3:0] INTENSITY    = 4'hA;
  localparam logic [3:0] SCAN_LIMIT   = 4'hB;
  localparam logic [3:0] SHUTDOWN     = 4'hC;
  localparam logic [3:0] DISPLAY_TEST = 4'hF;

  typedef struct packed {
    logic [7:0] decode;
    logic [3:0] intensity;
    logic [2:0] scan_limit;
    logic       shutdown;
    logic       display_test;
  } ctrl_t;

  function automatic logic is_digit(logic [3:0] addr);
    return (addr >= DIGIT0) && (addr <= DIGIT7);
  endfunction

endpackage

// File: rtl/silife_max7219_sink_reg.sv
// One emulated MAX7219: decodes a 12-bit command word
// (addr/data) into its digit rows and control registers.
module silife_max7219_sink_reg
  import silife_max7219_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        commit,
  input  logic [11:0] cmd,
  output logic [63:0] rows,
  output ctrl_t       ctrl
);

  logic [3:0] addr;
  logic [7:0] data;
  logic [2:0] row;

  assign addr = cmd[11:8];
  assign data = cmd[7:0];
  assign row  = 3'(addr - DIGIT0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows              <= '0;
      ctrl.decode       <= '0;
      ctrl.intensity    <= '0;
      ctrl.scan_limit   <= '0;
      ctrl.shutdown     <= 1'b1;
      ctrl.display_test <= 1'b0;
    end else if (commit) begin
      case (addr)
        NOOP:         ;
        DECODE:       ctrl.decode       <= data;
        INTENSITY:    ctrl.intensity    <= data[3:0];
        SCAN_LIMIT:   ctrl.scan_limit   <= data[2:0];
        SHUTDOWN:     ctrl.shutdown     <= ~data[0];
        DISPLAY_TEST: ctrl.display_test <= data[0];
        default: begin
          if (is_digit(addr))
            rows[{row, 3'b000} +: 8] <= data;
        end
      endcase
    end
  end

endmodule

// File: rtl/silife_max7219_sink.sv
// MAX7219 daisy-chain receiver: synchronises the SPI pins,
// shifts the chain and commits every device word on CS rise.
module silife_max7219_sink
  import silife_max7219_pkg::*;
#(
  parameter int DEVICES     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_cs,
  input  logic       i_sck,
  input  logic       i_mosi,
  output logic       o_dout,
  input  logic [3:0] i_device,
  input  logic [2:0] i_digit,
  output logic [7:0] o_digit_data,
  output logic [3:0] o_intensity,
  output logic [2:0] o_scan_limit,
  output logic [7:0] o_decode_mode,
  output logic       o_shutdown,
  output logic       o_display_test,
  output logic       o_latch,
  output logic       o_frame_error
);

  localparam int         W    = 16 * DEVICES;
  localparam logic [8:0] FULL = 9'(W);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic cs_s, sck_s, mosi_s;
  logic cs_prev, sck_prev;
  logic cs_rise, cs_fall, shift_en;

  logic [W-1:0] shift_q, shift_d;
  logic [8:0]   cnt_q, cnt_d;

  logic [DEVICES-1:0][63:0] rows_all;
  ctrl_t [DEVICES-1:0]      ctrl_all;
  logic [63:0]              sel_rows;
  ctrl_t                    sel_ctrl;

  // cs idles high through reset so release never looks like a commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync   <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_prev   <= 1'b1;
      sck_prev  <= 1'b0;
    end else begin
      cs_sync[0]   <= i_cs;
      sck_sync[0]  <= i_sck;
      mosi_sync[0] <= i_mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        cs_sync[i]   <= cs_sync[i-1];
        sck_sync[i]  <= sck_sync[i-1];
        mosi_sync[i] <= mosi_sync[i-1];
      end
      cs_prev  <= cs_s;
      sck_prev <= sck_s;
    end
  end

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign cs_rise  = cs_s & ~cs_prev;
  assign cs_fall  = ~cs_s & cs_prev;
  // gate on the previous cs so a final sck rise shifts before commit
  assign shift_en = sck_s & ~sck_prev & ~cs_prev;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (shift_en) begin
      shift_d = {shift_q[W-2:0], mosi_s};
      if (cnt_q != 9'h1FF)
        cnt_d = cnt_q + 9'd1;
    end
    if (cs_fall)
      cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q       <= '0;
      cnt_q         <= '0;
      o_dout        <= 1'b0;
      o_latch       <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      o_dout  <= shift_d[W-1];
      o_latch <= cs_rise;
      if (cs_rise && cnt_d != FULL)
        o_frame_error <= 1'b1;
    end
  end

  for (genvar k = 0; k < DEVICES; k++) begin : g_dev
    silife_max7219_sink_reg u_reg (
      .clk    (clk),
      .reset  (reset),
      .commit (cs_rise),
      .cmd    (shift_d[16*k +: 12]),
      .rows   (rows_all[k]),
      .ctrl   (ctrl_all[k])
    );
  end

  always_comb begin
    sel_rows = '0;
    sel_ctrl = '0;
    for (int k = 0; k < DEVICES; k++) begin
      if (i_device == 4'(k)) begin
        sel_rows = rows_all[k];
        sel_ctrl = ctrl_all[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_digit_data   <= '0;
      o_intensity    <= '0;
      o_scan_limit   <= '0;
      o_decode_mode  <= '0;
      o_shutdown     <= 1'b0;
      o_display_test <= 1'b0;
    end else begin
      o_digit_data   <= sel_rows[{i_digit, 3'b000} +: 8];
      o_intensity    <= sel_ctrl.intensity;
      o_scan_limit   <= sel_ctrl.scan_limit;
      o_decode_mode  <= sel_ctrl.decode;
      o_shutdown     <= sel_ctrl.shutdown;
      o_display_test <= sel_ctrl.display_test;
    end
  end

endmodule
